dest_reg_pipe: RTL and testbench
================================

# dest_reg_pipe

Parametrised successor to the destination-register select mux for the pipelined MIPS core. It selects the write-destination register in ID (rt, rd, link register, or no-write), then carries destination and write-valid through STAGES pipeline registers (EX…WB). Each cycle it compares the decoding instruction's source registers against every in-flight destination, producing hazard hits and a youngest-first forwarding select. It supports bubble insertion (stall), squash (flush) and whole-pipe freeze (hold).

## Interface
- REG_W, 5, register index width
- STAGES, 3, in-flight stages tracked (index 0 = EX, STAGES-1 = WB); legal range 2..8
- LINK_REG, 31, index written for dst_sel = 01
- FS_W, $clog2(STAGES+1), forwarding-select width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- dst_sel  in  2  00 rt, 01 LINK_REG, 10 rd, 11 no write
- reg_write  in  1  ID instruction writes a register
- rt, rd  in  REG_W  ID instruction fields
- rs_src, rt_src  in  REG_W  ID source registers to check
- stall  in  1  insert bubble into stage 0; later stages advance
- flush  in  1  squash ID instruction (bubble into stage 0)
- hold  in  1  freeze all stages
- id_dst  out  REG_W  combinational selected destination
- id_we  out  1  combinational effective write enable
- stage_dst  out  STAGES*REG_W  packed stage destinations, stage i at [i*REG_W +: REG_W]
- stage_vld  out  STAGES  per-stage write-valid
- wb_dst, wb_we  out  REG_W, 1  aliases of stage STAGES-1
- rs_hit, rt_hit  out  STAGES  per-stage match vectors
- rs_fwd, rt_fwd  out  FS_W  0 = no forward, k = forward from stage k-1 (youngest hit)

## Operation
- id_dst: rt/LINK_REG/rd per dst_sel; for 11, id_dst = 0.
- id_we = reg_write && dst_sel != 11 && id_dst != 0. Writes to $0 are never tracked.
- Update priority per cycle: rst > hold > normal.
  - rst: all stage_vld = 0, all stage_dst = 0.
  - hold: every stage keeps its value.
  - normal: stage i ← stage i-1 for i ≥ 1. Stage 0 ← {id_dst, id_we} unless stall or flush, in which case stage 0 ← {0, 0}.
  - Stall and flush together produce one bubble, same as either alone.
- Hits: rs_hit[i] = stage_vld[i] && stage_dst[i] == rs_src && rs_src != 0. rt_hit is the same with rt_src.
- rs_fwd = 1 + lowest i with rs_hit[i] set; 0 if none. rt_fwd is the same with rt_hit. Stage 0 (youngest) wins over older stages.
- Hits and fwd use current register contents and are not qualified by hold or stall.

## Timing
- id_dst, id_we, hits and fwd outputs are combinational. Stage outputs are registered.
- Latency: an ID instruction sampled at edge n appears in stage 0 after edge n and at WB after edge n+STAGES-1, given no hold.
- Each hold cycle adds exactly one cycle of latency to all stages.
- Reset value of every registered output is 0. rst asserted mid-stream clears all in-flight entries on the next edge, regardless of hold.
- The WB entry leaves on the next non-hold edge. There is no wrap; the oldest entry is discarded.

## Structure
- Shared package/header (mips_defs): DST_RT=2'b00, DST_LINK=2'b01, DST_RD=2'b10, DST_NONE=2'b11, and REG_ZERO.
- One sub-module, dest_sel_mux: combinational id_dst/id_we generation.
- Stage storage uses a generate loop. The priority encoder is instantiated twice, as a function or a loop.

## Test plan
- Reset and latency: rst 1 cycle, then rd=5, dst_sel=10, reg_write=1 for one cycle, STAGES=3 → stage_vld goes 001, 010, 100 on successive edges; wb_dst=5, wb_we=1 on the third edge; all outputs 0 right after reset.
- $0 and no-write: rd=0 with dst_sel=10, and rt=7 with dst_sel=11 → id_we=0 and bubbles propagate. rs_src=0 never hits.
- Link: dst_sel=01, reg_write=1 → id_dst=31. Next cycle, rs_src=31 → rs_hit=001, rs_fwd=1.
- Youngest-wins: issue writes to r9 on two consecutive cycles → rs_src=9 gives rs_hit=011, rs_fwd=1. After one more plain edge, rs_hit=110, rs_fwd=2.
- Stall/flush/hold: stall and flush together with id_we=1 → stage 0 becomes a bubble while older stages shift. hold for 2 cycles → stage contents are unchanged. rst during hold → all clear.
- Parameter sweep: STAGES=2 and 8, REG_W=5 → WB latency equals STAGES edges; fwd width is 2 and 4 respectively.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS decode constants: destination-select encodings and the zero register.
// Pure definitions, no logic, latency or flow control.
package mips_defs;
  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_LINK = 2'b01;
  localparam logic [1:0] DST_RD   = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  localparam int REG_ZERO = 0;
endpackage

// File: rtl/dest_sel_mux.sv
// Picks the ID-stage write destination and its effective write enable.
// Purely combinational; no backpressure.
module dest_sel_mux
  import mips_defs::*;
#(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic [1:0]       dst_sel,
  input  logic             reg_write,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] id_dst,
  output logic             id_we
);

  always_comb begin
    id_dst = '0;
    case (dst_sel)
      DST_RT:   id_dst = rt;
      DST_LINK: id_dst = REG_W'(LINK_REG);
      DST_RD:   id_dst = rd;
      default:  id_dst = '0;
    endcase
  end

  // $0 is hardwired, so a write to it never needs tracking.
  assign id_we = reg_write && (dst_sel != DST_NONE) && (id_dst != REG_W'(REG_ZERO));

endmodule

// File: rtl/dest_reg_pipe.sv
// Tracks in-flight write destinations EX..WB and reports hazards/forwarding for ID sources.
// Stage 0 loads one edge after ID; WB after STAGES edges. hold freezes all stages.
module dest_reg_pipe
  import mips_defs::*;
#(
  parameter int REG_W    = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31,
  parameter int FS_W     = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              dst_sel,
  input  logic                    reg_write,
  input  logic [REG_W-1:0]        rt,
  input  logic [REG_W-1:0]        rd,
  input  logic [REG_W-1:0]        rs_src,
  input  logic [REG_W-1:0]        rt_src,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    hold,
  output logic [REG_W-1:0]        id_dst,
  output logic                    id_we,
  output logic [STAGES*REG_W-1:0] stage_dst,
  output logic [STAGES-1:0]       stage_vld,
  output logic [REG_W-1:0]        wb_dst,
  output logic                    wb_we,
  output logic [STAGES-1:0]       rs_hit,
  output logic [STAGES-1:0]       rt_hit,
  output logic [FS_W-1:0]         rs_fwd,
  output logic [FS_W-1:0]         rt_fwd
);

  logic [REG_W-1:0]  dst_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic              bubble;

  dest_sel_mux #(
    .REG_W    (REG_W),
    .LINK_REG (LINK_REG)
  ) u_dest_sel_mux (
    .dst_sel   (dst_sel),
    .reg_write (reg_write),
    .rt        (rt),
    .rd        (rd),
    .id_dst    (id_dst),
    .id_we     (id_we)
  );

  // Stall and flush both mean "ID does not issue"; together they still cost one bubble.
  assign bubble = stall || flush;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          dst_q[0] <= '0;
          vld_q[0] <= 1'b0;
        end else if (!hold) begin
          dst_q[0] <= bubble ? '0 : id_dst;
          vld_q[0] <= bubble ? 1'b0 : id_we;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          dst_q[i] <= '0;
          vld_q[i] <= 1'b0;
        end else if (!hold) begin
          dst_q[i] <= dst_q[i-1];
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    assign stage_dst[i*REG_W +: REG_W] = dst_q[i];

    assign rs_hit[i] = vld_q[i] && (dst_q[i] == rs_src) && (rs_src != REG_W'(REG_ZERO));
    assign rt_hit[i] = vld_q[i] && (dst_q[i] == rt_src) && (rt_src != REG_W'(REG_ZERO));
  end

  assign stage_vld = vld_q;
  assign wb_dst    = dst_q[STAGES-1];
  assign wb_we     = vld_q[STAGES-1];

  // Youngest hit wins: scan oldest to youngest so the lowest index overwrites.
  function automatic logic [FS_W-1:0] youngest_hit(input logic [STAGES-1:0] hit);
    logic [FS_W-1:0] sel;
    sel = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hit[k]) sel = FS_W'(k + 1);
    end
    return sel;
  endfunction

  assign rs_fwd = youngest_hit(rs_hit);
  assign rt_fwd = youngest_hit(rt_hit);

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Drives three pipe depths (2, 3, 8) from one stimulus stream and checks them against
// a history-list model: stage i of any depth holds the ID result from i+1 advancing edges ago.
module tb_dest_reg_pipe;
  import mips_defs::*;

  logic       clk;
  logic       rst;
  logic [1:0] dst_sel;
  logic       reg_write;
  logic [4:0] rt, rd, rs_src, rt_src;
  logic       stall, flush, hold;

  logic [4:0]  o2_id_dst, o3_id_dst, o8_id_dst;
  logic        o2_id_we, o3_id_we, o8_id_we;
  logic [9:0]  o2_sd;
  logic [14:0] o3_sd;
  logic [39:0] o8_sd;
  logic [1:0]  o2_vld, o2_rsh, o2_rth;
  logic [2:0]  o3_vld, o3_rsh, o3_rth;
  logic [7:0]  o8_vld, o8_rsh, o8_rth;
  logic [4:0]  o2_wbd, o3_wbd, o8_wbd;
  logic        o2_wbw, o3_wbw, o8_wbw;
  logic [1:0]  o2_rsf, o2_rtf, o3_rsf, o3_rtf;
  logic [3:0]  o8_rsf, o8_rtf;

  int checks = 0;
  int errors = 0;

  logic [4:0] h_dst [8];
  logic       h_we  [8];

  dest_reg_pipe #(.REG_W(5), .STAGES(2), .LINK_REG(31)) dut2 (
    .clk(clk), .rst(rst), .dst_sel(dst_sel), .reg_write(reg_write), .rt(rt), .rd(rd),
    .rs_src(rs_src), .rt_src(rt_src), .stall(stall), .flush(flush), .hold(hold),
    .id_dst(o2_id_dst), .id_we(o2_id_we), .stage_dst(o2_sd), .stage_vld(o2_vld),
    .wb_dst(o2_wbd), .wb_we(o2_wbw), .rs_hit(o2_rsh), .rt_hit(o2_rth),
    .rs_fwd(o2_rsf), .rt_fwd(o2_rtf));

  dest_reg_pipe #(.REG_W(5), .STAGES(3), .LINK_REG(31)) dut3 (
    .clk(clk), .rst(rst), .dst_sel(dst_sel), .reg_write(reg_write), .rt(rt), .rd(rd),
    .rs_src(rs_src), .rt_src(rt_src), .stall(stall), .flush(flush), .hold(hold),
    .id_dst(o3_id_dst), .id_we(o3_id_we), .stage_dst(o3_sd), .stage_vld(o3_vld),
    .wb_dst(o3_wbd), .wb_we(o3_wbw), .rs_hit(o3_rsh), .rt_hit(o3_rth),
    .rs_fwd(o3_rsf), .rt_fwd(o3_rtf));

  dest_reg_pipe #(.REG_W(5), .STAGES(8), .LINK_REG(31)) dut8 (
    .clk(clk), .rst(rst), .dst_sel(dst_sel), .reg_write(reg_write), .rt(rt), .rd(rd),
    .rs_src(rs_src), .rt_src(rt_src), .stall(stall), .flush(flush), .hold(hold),
    .id_dst(o8_id_dst), .id_we(o8_id_we), .stage_dst(o8_sd), .stage_vld(o8_vld),
    .wb_dst(o8_wbd), .wb_we(o8_wbw), .rs_hit(o8_rsh), .rt_hit(o8_rth),
    .rs_fwd(o8_rsf), .rt_fwd(o8_rtf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_id_dst();
    case (dst_sel)
      2'b00:   return rt;
      2'b01:   return 5'd31;
      2'b10:   return rd;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic m_id_we();
    return reg_write && dst_sel != 2'b11 && m_id_dst() != 5'd0;
  endfunction

  function automatic logic [63:0] m_sd(input int s);
    logic [63:0] r = '0;
    for (int i = 0; i < s; i++) r[i*5 +: 5] = h_dst[i];
    return r;
  endfunction

  function automatic logic [63:0] m_vld(input int s);
    logic [63:0] r = '0;
    for (int i = 0; i < s; i++) r[i] = h_we[i];
    return r;
  endfunction

  function automatic logic [63:0] m_hit(input int s, input logic [4:0] src);
    logic [63:0] r = '0;
    for (int i = 0; i < s; i++) r[i] = h_we[i] && h_dst[i] == src && src != 5'd0;
    return r;
  endfunction

  function automatic logic [63:0] m_fwd(input int s, input logic [4:0] src);
    for (int i = 0; i < s; i++)
      if (h_we[i] && h_dst[i] == src && src != 5'd0) return 64'(i + 1);
    return 64'd0;
  endfunction

  task automatic chk_dut(input int s, input string nm,
                         input logic [63:0] idd, input logic [63:0] idw,
                         input logic [63:0] sd, input logic [63:0] vld,
                         input logic [63:0] wbd, input logic [63:0] wbw,
                         input logic [63:0] rsh, input logic [63:0] rth,
                         input logic [63:0] rsf, input logic [63:0] rtf);
    chk({nm, ".id_dst"}, idd, 64'(m_id_dst()));
    chk({nm, ".id_we"}, idw, 64'(m_id_we()));
    chk({nm, ".stage_dst"}, sd, m_sd(s));
    chk({nm, ".stage_vld"}, vld, m_vld(s));
    chk({nm, ".wb_dst"}, wbd, 64'(h_dst[s-1]));
    chk({nm, ".wb_we"}, wbw, 64'(h_we[s-1]));
    chk({nm, ".rs_hit"}, rsh, m_hit(s, rs_src));
    chk({nm, ".rt_hit"}, rth, m_hit(s, rt_src));
    chk({nm, ".rs_fwd"}, rsf, m_fwd(s, rs_src));
    chk({nm, ".rt_fwd"}, rtf, m_fwd(s, rt_src));
  endtask

  task automatic check_all();
    chk_dut(2, "s2", 64'(o2_id_dst), 64'(o2_id_we), 64'(o2_sd), 64'(o2_vld), 64'(o2_wbd),
            64'(o2_wbw), 64'(o2_rsh), 64'(o2_rth), 64'(o2_rsf), 64'(o2_rtf));
    chk_dut(3, "s3", 64'(o3_id_dst), 64'(o3_id_we), 64'(o3_sd), 64'(o3_vld), 64'(o3_wbd),
            64'(o3_wbw), 64'(o3_rsh), 64'(o3_rth), 64'(o3_rsf), 64'(o3_rtf));
    chk_dut(8, "s8", 64'(o8_id_dst), 64'(o8_id_we), 64'(o8_sd), 64'(o8_vld), 64'(o8_wbd),
            64'(o8_wbw), 64'(o8_rsh), 64'(o8_rth), 64'(o8_rsf), 64'(o8_rtf));
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        h_dst[i] = '0;
        h_we[i]  = 1'b0;
      end
    end else if (!hold) begin
      for (int i = 7; i > 0; i--) begin
        h_dst[i] = h_dst[i-1];
        h_we[i]  = h_we[i-1];
      end
      h_dst[0] = (stall || flush) ? 5'd0 : m_id_dst();
      h_we[0]  = (stall || flush) ? 1'b0 : m_id_we();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [4:0] pick_reg();
    int v = $urandom_range(0, 8);
    return (v == 8) ? 5'd31 : 5'(v);
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      h_dst[i] = '0;
      h_we[i]  = 1'b0;
    end
    rst = 1'b1; dst_sel = 2'b11; reg_write = 1'b0; rt = '0; rd = '0;
    rs_src = '0; rt_src = '0; stall = 1'b0; flush = 1'b0; hold = 1'b0;
    @(negedge clk);
    step();
    chk("reset.vld", 64'(o3_vld), 64'd0);
    chk("reset.wb_dst", 64'(o3_wbd), 64'd0);
    chk("reset.rs_fwd", 64'(o3_rsf), 64'd0);

    // Latency: rd=5 walks 001 -> 010 -> 100.
    rst = 1'b0; dst_sel = 2'b10; rd = 5'd5; reg_write = 1'b1;
    #1;
    chk("lat.id_dst", 64'(o3_id_dst), 64'd5);
    chk("lat.id_we", 64'(o3_id_we), 64'd1);
    step();
    chk("lat.e1", 64'(o3_vld), 64'b001);
    dst_sel = 2'b11; reg_write = 1'b0;
    step();
    chk("lat.e2", 64'(o3_vld), 64'b010);
    step();
    chk("lat.e3", 64'(o3_vld), 64'b100);
    chk("lat.wb_dst", 64'(o3_wbd), 64'd5);
    chk("lat.wb_we", 64'(o3_wbw), 64'd1);

    // $0 and no-write.
    dst_sel = 2'b10; rd = 5'd0; reg_write = 1'b1;
    #1;
    chk("zero.id_we", 64'(o3_id_we), 64'd0);
    step();
    dst_sel = 2'b11; rt = 5'd7;
    #1;
    chk("none.id_we", 64'(o3_id_we), 64'd0);
    chk("none.id_dst", 64'(o3_id_dst), 64'd0);
    step();

    // Link register.
    dst_sel = 2'b01;
    #1;
    chk("link.id_dst", 64'(o3_id_dst), 64'd31);
    step();
    dst_sel = 2'b11; rs_src = 5'd31;
    #1;
    chk("link.rs_hit", 64'(o3_rsh), 64'b001);
    chk("link.rs_fwd", 64'(o3_rsf), 64'd1);

    // Youngest wins.
    rst = 1'b1;
    step();
    rst = 1'b0; dst_sel = 2'b10; rd = 5'd9; rs_src = 5'd9;
    step();
    step();
    dst_sel = 2'b11;
    #1;
    chk("young.rs_hit", 64'(o3_rsh), 64'b011);
    chk("young.rs_fwd", 64'(o3_rsf), 64'd1);
    step();
    chk("old.rs_hit", 64'(o3_rsh), 64'b110);
    chk("old.rs_fwd", 64'(o3_rsf), 64'd2);

    // Stall+flush, hold, reset under hold.
    dst_sel = 2'b10; rd = 5'd9; stall = 1'b1; flush = 1'b1;
    step();
    chk("bubble.vld", 64'(o3_vld), 64'b100);
    stall = 1'b0; flush = 1'b0; hold = 1'b1;
    step();
    step();
    chk("hold.vld", 64'(o3_vld), 64'b100);
    chk("hold.wb_dst", 64'(o3_wbd), 64'd9);
    rst = 1'b1;
    step();
    chk("rsthold.vld", 64'(o8_vld), 64'd0);
    rst = 1'b0; hold = 1'b0;

    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      hold      = ($urandom_range(0, 99) < 15);
      stall     = ($urandom_range(0, 99) < 10);
      flush     = ($urandom_range(0, 99) < 10);
      dst_sel   = 2'($urandom_range(0, 3));
      reg_write = ($urandom_range(0, 99) < 80);
      rt        = pick_reg();
      rd        = pick_reg();
      rs_src    = pick_reg();
      rt_src    = pick_reg();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
